id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Execute-stage operand register that sits directly upstream of the ALU in the pipelined MIPS core. It accepts decoded instructions from the ID stage, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, selects immediate/shift-amount operands, and presents registered `a`, `b` and `control` values to the ALU. A 2-entry skid buffer with valid/ready handshakes on both sides decouples ID from EX stalls without a combinational ready path.

## Interface
- `LENGTH`, 32, datapath width
- `CONTROL_LENGTH`, 4, ALU control width
- `REG_ADDR`, 5, register-file address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  ID presents an instruction
- `in_ready`  out  1  stage can accept (registered)
- `in_rs_val`, `in_rt_val`  in  LENGTH  register-file read data
- `in_imm`  in  LENGTH  already-extended immediate
- `in_shamt`  in  5  shift amount field
- `in_control`  in  CONTROL_LENGTH  ALU operation code
- `in_use_imm`, `in_use_shamt`  in  1  operand-select flags
- `in_rs_addr`, `in_rt_addr`, `in_rd_addr`  in  REG_ADDR  source/destination registers
- `in_reg_write`  in  1  instruction writes `in_rd_addr`
- `exmem_write`, `memwb_write`  in  1  forwarding source valid
- `exmem_addr`, `memwb_addr`  in  REG_ADDR  forwarding destination
- `exmem_data`, `memwb_data`  in  LENGTH  forwarding data
- `flush`  in  1  synchronous pipeline flush
- `out_valid`  out  1  ALU operands valid
- `out_ready`  in  1  EX consumes this cycle
- `alu_a`, `alu_b`  out  LENGTH  ALU operands
- `alu_control`  out  CONTROL_LENGTH  ALU operation code
- `out_rd_addr`  out  REG_ADDR, `out_reg_write`  out  1  passed to EX/MEM

## Operation
- Forwarding, evaluated on the accept cycle only, per source (rs, rt) independently:
  - source address 0 never forwarded; value used is `in_*_val`
  - EX/MEM match (`exmem_write` and addr equal) wins over MEM/WB match
  - else MEM/WB match, else register-file value
- Operand select (after forwarding):
  - `alu_a` = `in_use_shamt` ? {zeros, `in_shamt`} : forwarded rs
  - `alu_b` = `in_use_imm` ? `in_imm` : forwarded rt
  - matches ALU convention: shifts compute `b` shifted by `a`; lui uses `b` only
- Entries are fully resolved on capture; held entries are not re-snooped. Hazard unit guarantees no producer retires while a dependent entry waits.
- Storage: main register (drives outputs) + skid register. States:
  - EMPTY: `out_valid`=0, `in_ready`=1
  - ONE: main full, `in_ready`=1
  - TWO: both full, `in_ready`=0
- Transitions (acc = `in_valid`&`in_ready`, pop = `out_valid`&`out_ready`):
  - EMPTY: acc → ONE (into main)
  - ONE: acc&!pop → TWO (into skid); !acc&pop → EMPTY; acc&pop → ONE (new entry into main)
  - TWO: pop → ONE (skid moves to main); no accept possible
- `flush` dominates: next state EMPTY, any same-cycle accept discarded, same-cycle pop still counts as consumed by EX.
- Order preserved strictly; no entry dropped or duplicated except by flush.

## Timing
- Reset (async assert, sync-to-clock release): state EMPTY, `in_ready`=1, `out_valid`=0, `alu_a`/`alu_b`/`alu_control`/`out_rd_addr`/`out_reg_write`=0.
- Latency: accept in cycle N → on outputs cycle N+1 when EMPTY or popping.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- `in_ready` is a flop output; no combinational path from `out_ready` or `flush` to `in_ready`.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Flush at cycle N: `out_valid`=0 and `in_ready`=1 from cycle N+1.
- Reset mid-operation: all entries lost immediately, outputs at reset values.

## Test plan
- Back-to-back: 8 ADD ops, `out_ready`=1 → each appears 1 cycle later, `out_valid` continuous, `in_ready` never drops.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → TWO reached after 2 accepts, `in_ready`=0, outputs hold first entry; release → entries 1,2,3 in order.
- Forwarding: rs=5, `exmem_addr`=5 data 0x11, `memwb_addr`=5 data 0x22 → `alu_a`=0x11; rs=0 with `exmem_addr`=0 → register value used.
- Operand select: shamt=4, `in_use_shamt`=1, control 7, rt=0x1 → `alu_a`=4, `alu_b`=1; `in_use_imm`=1 imm 0xFFFF_FFF0 → `alu_b`=0xFFFF_FFF0.
- Flush in TWO with simultaneous `in_valid` → next cycle `out_valid`=0, `in_ready`=1, flushed entries never appear.
- Async reset asserted mid-stream between clock edges → outputs 0, `in_ready`=1 immediately; first post-reset accept appears normally.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX operand register: forwards from EX/MEM and MEM/WB, selects shamt/imm
// operands, and holds up to two resolved entries in a main + skid buffer.
module id_ex_stage #(
    parameter int LENGTH         = 32,
    parameter int CONTROL_LENGTH = 4,
    parameter int REG_ADDR       = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LENGTH-1:0]         in_rs_val,
    input  logic [LENGTH-1:0]         in_rt_val,
    input  logic [LENGTH-1:0]         in_imm,
    input  logic [4:0]                in_shamt,
    input  logic [CONTROL_LENGTH-1:0] in_control,
    input  logic                      in_use_imm,
    input  logic                      in_use_shamt,
    input  logic [REG_ADDR-1:0]       in_rs_addr,
    input  logic [REG_ADDR-1:0]       in_rt_addr,
    input  logic [REG_ADDR-1:0]       in_rd_addr,
    input  logic                      in_reg_write,

    input  logic                      exmem_write,
    input  logic [REG_ADDR-1:0]       exmem_addr,
    input  logic [LENGTH-1:0]         exmem_data,
    input  logic                      memwb_write,
    input  logic [REG_ADDR-1:0]       memwb_addr,
    input  logic [LENGTH-1:0]         memwb_data,

    input  logic                      flush,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LENGTH-1:0]         alu_a,
    output logic [LENGTH-1:0]         alu_b,
    output logic [CONTROL_LENGTH-1:0] alu_control,
    output logic [REG_ADDR-1:0]       out_rd_addr,
    output logic                      out_reg_write
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    typedef struct packed {
        logic [LENGTH-1:0]         a;
        logic [LENGTH-1:0]         b;
        logic [CONTROL_LENGTH-1:0] ctrl;
        logic [REG_ADDR-1:0]       rd;
        logic                      rw;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       in_ready_q, in_ready_d;

    logic       acc, pop;
    entry_t     new_e;
    logic [LENGTH-1:0] rs_fwd, rt_fwd;

    // $zero is hardwired, so a producer "writing" r0 must never be forwarded.
    function automatic logic [LENGTH-1:0] fwd(
        input logic [REG_ADDR-1:0] src,
        input logic [LENGTH-1:0]   rf_val,
        input logic                ex_w,
        input logic [REG_ADDR-1:0] ex_a,
        input logic [LENGTH-1:0]   ex_d,
        input logic                wb_w,
        input logic [REG_ADDR-1:0] wb_a,
        input logic [LENGTH-1:0]   wb_d
    );
        logic [LENGTH-1:0] r;
        r = rf_val;
        if (src != '0) begin
            if (ex_w && (ex_a == src))      r = ex_d;
            else if (wb_w && (wb_a == src)) r = wb_d;
        end
        return r;
    endfunction

    assign rs_fwd = fwd(in_rs_addr, in_rs_val, exmem_write, exmem_addr, exmem_data,
                        memwb_write, memwb_addr, memwb_data);
    assign rt_fwd = fwd(in_rt_addr, in_rt_val, exmem_write, exmem_addr, exmem_data,
                        memwb_write, memwb_addr, memwb_data);

    always_comb begin
        new_e      = '0;
        new_e.a    = in_use_shamt ? {{(LENGTH-5){1'b0}}, in_shamt} : rs_fwd;
        new_e.b    = in_use_imm ? in_imm : rt_fwd;
        new_e.ctrl = in_control;
        new_e.rd   = in_rd_addr;
        new_e.rw   = in_reg_write;
    end

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (acc) begin
                    main_d  = new_e;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (acc && !pop) begin
                    skid_d  = new_e;
                    state_d = S_TWO;
                end else if (acc && pop) begin
                    main_d  = new_e;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush drops everything held, including a same-cycle accept.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Ready is derived from the next state so it can be registered.
    assign in_ready_d = (state_d != S_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign alu_a         = main_q.a;
    assign alu_b         = main_q.b;
    assign alu_control   = main_q.ctrl;
    assign out_rd_addr   = main_q.rd;
    assign out_reg_write = main_q.rw;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed
// operands; a negedge monitor checks every presented entry in order.
module tb_id_ex_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs_val, in_rt_val, in_imm;
    logic [4:0]  in_shamt;
    logic [3:0]  in_control;
    logic        in_use_imm, in_use_shamt;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic        in_reg_write;
    logic        exmem_write, memwb_write;
    logic [4:0]  exmem_addr, memwb_addr;
    logic [31:0] exmem_data, memwb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_control(in_control),
        .in_use_imm(in_use_imm), .in_use_shamt(in_use_shamt),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .in_reg_write(in_reg_write),
        .exmem_write(exmem_write), .memwb_write(memwb_write),
        .exmem_addr(exmem_addr), .memwb_addr(memwb_addr),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every presented entry must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got a=%h b=%h want nothing", alu_a, alu_b);
            end else begin
                chk("out", {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write},
                    {sb[0].a, sb[0].b, sb[0].c, sb[0].rd, sb[0].rw});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] rsv, rtv, imm, input logic [4:0] sh,
                        input logic [3:0] c, input logic ui, us,
                        input logic [4:0] rs, rt, rd, input logic rw,
                        input logic [31:0] ea, eb);
        int n;
        in_rs_val = rsv; in_rt_val = rtv; in_imm = imm; in_shamt = sh;
        in_control = c; in_use_imm = ui; in_use_shamt = us;
        in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd; in_reg_write = rw;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{ea, eb, c, rd, rw});
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_rs_val = '0; in_rt_val = '0; in_imm = '0; in_shamt = '0; in_control = '0;
        in_use_imm = 1'b0; in_use_shamt = 1'b0;
        in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0; in_reg_write = 1'b0;
        exmem_write = 1'b0; memwb_write = 1'b0; exmem_addr = '0; memwb_addr = '0;
        exmem_data = '0; memwb_data = '0;

        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write}, '0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);

        // Back-to-back ADDs
        for (int i = 0; i < 8; i++) begin
            send(32'(i * 3), 32'(i + 100), 32'h0, 5'd0, 4'd2, 1'b0, 1'b0,
                 5'(i + 1), 5'(i + 9), 5'(i + 2), 1'b1, 32'(i * 3), 32'(i + 100));
            chk("b2b_valid", out_valid, 1'b1);
            chk("b2b_ready", in_ready, 1'b1);
        end
        idle(2);

        // Backpressure: fill to TWO, hold, then release
        out_ready = 1'b0;
        send(32'hA1, 32'hA2, 0, 0, 4'd2, 0, 0, 5'd1, 5'd2, 5'd3, 1'b1, 32'hA1, 32'hA2);
        send(32'hB1, 32'hB2, 0, 0, 4'd3, 0, 0, 5'd1, 5'd2, 5'd4, 1'b0, 32'hB1, 32'hB2);
        chk("two_in_ready", in_ready, 1'b0);
        chk("two_hold_a", alu_a, 32'hA1);
        fork
            send(32'hC1, 32'hC2, 0, 0, 4'd4, 0, 0, 5'd1, 5'd2, 5'd5, 1'b1, 32'hC1, 32'hC2);
            begin
                idle(2);
                chk("two_still_full", in_ready, 1'b0);
                chk("two_hold_a2", alu_a, 32'hA1);
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Forwarding
        exmem_write = 1'b1; exmem_addr = 5'd5; exmem_data = 32'h11;
        memwb_write = 1'b1; memwb_addr = 5'd5; memwb_data = 32'h22;
        send(32'h99, 32'h77, 0, 0, 4'd2, 0, 0, 5'd5, 5'd5, 5'd8, 1'b1, 32'h11, 32'h11);
        exmem_addr = 5'd6;
        send(32'h99, 32'h77, 0, 0, 4'd2, 0, 0, 5'd5, 5'd6, 5'd8, 1'b1, 32'h22, 32'h11);
        exmem_addr = 5'd0; memwb_addr = 5'd0;
        send(32'h33, 32'h44, 0, 0, 4'd2, 0, 0, 5'd0, 5'd0, 5'd8, 1'b1, 32'h33, 32'h44);
        exmem_write = 1'b0; memwb_write = 1'b0; exmem_addr = 5'd7; memwb_addr = 5'd7;
        send(32'h55, 32'h66, 0, 0, 4'd2, 0, 0, 5'd7, 5'd7, 5'd8, 1'b1, 32'h55, 32'h66);

        // Operand select (forwarding still targets r7; must be overridden)
        exmem_write = 1'b1;
        send(32'hDEAD, 32'h1, 0, 5'd4, 4'd7, 1'b0, 1'b1, 5'd7, 5'd3, 5'd4, 1'b1, 32'h4, 32'h1);
        send(32'h5, 32'h6, 32'hFFFF_FFF0, 0, 4'd1, 1'b1, 1'b0, 5'd2, 5'd7, 5'd9, 1'b1,
             32'h5, 32'hFFFF_FFF0);
        send(32'h5, 32'h6, 32'h8, 5'd31, 4'd6, 1'b1, 1'b1, 5'd2, 5'd3, 5'd9, 1'b0,
             32'd31, 32'h8);
        exmem_write = 1'b0;
        idle(2);

        // Flush in TWO with a simultaneous incoming instruction
        out_ready = 1'b0;
        send(32'hD1, 32'hD2, 0, 0, 4'd2, 0, 0, 5'd1, 5'd2, 5'd3, 1'b1, 32'hD1, 32'hD2);
        send(32'hE1, 32'hE2, 0, 0, 4'd2, 0, 0, 5'd1, 5'd2, 5'd3, 1'b1, 32'hE1, 32'hE2);
        chk("flush_pre_two", in_ready, 1'b0);
        in_rs_val = 32'hF1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        idle(2);
        chk("flush_stays_empty", out_valid, 1'b0);
        send(32'h61, 32'h62, 0, 0, 4'd5, 0, 0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h61, 32'h62);
        idle(2);

        // Async reset mid-stream, between clock edges
        send(32'h71, 32'h72, 0, 0, 4'd9, 0, 0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h71, 32'h72);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_outputs", {alu_a, alu_b, alu_control, out_rd_addr, out_reg_write}, '0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        idle(1);
        send(32'h81, 32'h82, 0, 0, 4'd3, 0, 0, 5'd1, 5'd2, 5'd6, 1'b1, 32'h81, 32'h82);
        chk("post_rst_latency", out_valid, 1'b1);
        idle(3);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
